// File: rtl/st3_pkg.sv
// Shared types and parameter-consistency helpers for the stage-3 ping-pong controller.
package st3_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_VALID = 2'd2
  } rstate_e;

  function automatic int rows_of(input int out_addr_width);
    return 32'sd1 << out_addr_width;
  endfunction

  function automatic int words_of(input int in_addr_width);
    return 32'sd1 << in_addr_width;
  endfunction

  function automatic bit rows_ok(input int channel_num, input int out_addr_width);
    return channel_num == rows_of(out_addr_width);
  endfunction

  function automatic bit width_ok(input int out_data_width, input int in_data_width,
                                  input int in_addr_width);
    return out_data_width == in_data_width * words_of(in_addr_width);
  endfunction

  // Latency counter must hold LATENCY-1 and never collapse to zero bits.
  function automatic int lat_width(input int latency);
    return (latency > 32'sd1) ? $clog2(latency) : 32'sd1;
  endfunction

endpackage

// File: rtl/st3_param_chk.sv
// Elaboration-time parameter checks and run-time protocol properties for st3_pp_ctrl.
module st3_param_chk
  import st3_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int IN_ADDR_WIDTH  = 7,
  parameter int OUT_DATA_WIDTH = 8192,
  parameter int OUT_ADDR_WIDTH = 2,
  parameter int CHANNEL_NUM    = 4,
  parameter int LATENCY        = 1
) (
  input logic clk,
  input logic rst_n,
  input logic st3_sel,
  input logic rd_idle,
  input logic st3_wen,
  input logic in_ready,
  input logic out_valid,
  input logic out_last
);

  generate
    if (!width_ok(OUT_DATA_WIDTH, IN_DATA_WIDTH, IN_ADDR_WIDTH)) begin : g_bad_width
      $error("OUT_DATA_WIDTH must equal IN_DATA_WIDTH * 2**IN_ADDR_WIDTH");
    end
    if (!rows_ok(CHANNEL_NUM, OUT_ADDR_WIDTH)) begin : g_bad_rows
      $error("CHANNEL_NUM must equal 2**OUT_ADDR_WIDTH");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $error("LATENCY must be at least 1");
    end
  endgenerate

  // Bank select may only move on the swap edge, which requires an idle read side.
  a_sel_stable: assert property (@(posedge clk) disable iff (!rst_n)
    !rd_idle |=> $stable(st3_sel))
    else $error("st3_sel changed while the read side was busy");

  a_wen_ready: assert property (@(posedge clk) disable iff (!rst_n)
    st3_wen |-> in_ready)
    else $error("st3_wen asserted while in_ready low");

  a_last_valid: assert property (@(posedge clk) disable iff (!rst_n)
    out_last |-> out_valid)
    else $error("out_last asserted without out_valid");

endmodule

// File: rtl/st3_rd_seq.sv
// Read-side sequencer: swaps banks on request, waits out the buffer latency, and walks rows.
module st3_rd_seq
  import st3_pkg::*;
#(
  parameter int OUT_ADDR_WIDTH = 2,
  parameter int CHANNEL_NUM    = 4,
  parameter int LATENCY        = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      swap_req,
  input  logic                      out_ready,
  output logic                      swap_ack,
  output logic                      idle,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [OUT_ADDR_WIDTH-1:0] raddr
);

  localparam int                      LAT_W      = lat_width(LATENCY);
  localparam logic [LAT_W-1:0]        LAT_RELOAD = LAT_W'(LATENCY - 32'sd1);
  localparam logic [LAT_W-1:0]        LAT_ZERO   = {LAT_W{1'b0}};
  localparam logic [OUT_ADDR_WIDTH-1:0] LAST_ROW = OUT_ADDR_WIDTH'(CHANNEL_NUM - 32'sd1);
  localparam logic [OUT_ADDR_WIDTH-1:0] ROW_ZERO = {OUT_ADDR_WIDTH{1'b0}};
  localparam logic [OUT_ADDR_WIDTH-1:0] ROW_ONE  = OUT_ADDR_WIDTH'(32'd1);

  rstate_e                   rstate_q, rstate_d;
  logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
  logic [OUT_ADDR_WIDTH-1:0] raddr_q, raddr_d;

  // State, latency counter and row address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q  <= R_IDLE;
      lat_cnt_q <= LAT_ZERO;
      raddr_q   <= ROW_ZERO;
    end else begin
      rstate_q  <= rstate_d;
      lat_cnt_q <= lat_cnt_d;
      raddr_q   <= raddr_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    rstate_d  = rstate_q;
    lat_cnt_d = lat_cnt_q;
    raddr_d   = raddr_q;
    swap_ack  = 1'b0;
    idle      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        idle = 1'b1;
        if (swap_req) begin
          swap_ack  = 1'b1;
          raddr_d   = ROW_ZERO;
          lat_cnt_d = LAT_RELOAD;
          rstate_d  = R_WAIT;
        end else begin
          rstate_d  = R_IDLE;
        end
      end
      R_WAIT: begin
        if (lat_cnt_q == LAT_ZERO) begin
          rstate_d  = R_VALID;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(32'd1);
        end
      end
      R_VALID: begin
        out_valid = 1'b1;
        out_last  = (raddr_q == LAST_ROW);
        // Row address only moves on acceptance, so the buffer output stays stable while stalled.
        if (out_ready) begin
          if (raddr_q == LAST_ROW) begin
            rstate_d  = R_IDLE;
          end else begin
            raddr_d   = raddr_q + ROW_ONE;
            lat_cnt_d = LAT_RELOAD;
            rstate_d  = R_WAIT;
          end
        end else begin
          rstate_d  = R_VALID;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  assign raddr = raddr_q;

endmodule

// File: rtl/st3_pp_ctrl.sv
// Stage-3 ping-pong controller: fills one bank from the input stream while the other
// bank is drained row by row to the consumer.
module st3_pp_ctrl
  import st3_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int IN_ADDR_WIDTH  = 7,
  parameter int OUT_DATA_WIDTH = 8192,
  parameter int OUT_ADDR_WIDTH = 2,
  parameter int CHANNEL_NUM    = 4,
  parameter int LATENCY        = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [CHANNEL_NUM-1:0][IN_DATA_WIDTH-1:0] in_data,
  output logic                                      st3_sel,
  output logic                                      st3_wen,
  output logic [IN_ADDR_WIDTH-1:0]                  st3_waddr,
  output logic [CHANNEL_NUM-1:0][IN_DATA_WIDTH-1:0] st3_wdata,
  output logic [OUT_ADDR_WIDTH-1:0]                 st3_raddr,
  input  logic [OUT_DATA_WIDTH-1:0]                 st3_rdata,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0]                 out_data,
  output logic                                      out_last
);

  localparam logic [IN_ADDR_WIDTH-1:0] WCNT_MAX  = {IN_ADDR_WIDTH{1'b1}};
  localparam logic [IN_ADDR_WIDTH-1:0] WCNT_ZERO = {IN_ADDR_WIDTH{1'b0}};
  localparam logic [IN_ADDR_WIDTH-1:0] WCNT_ONE  = IN_ADDR_WIDTH'(32'd1);

  logic [IN_ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                     wfull_q, wfull_d;
  logic                     sel_q, sel_d;
  logic                     wr_fire_s;
  logic                     swap_ack_s;
  logic                     rd_idle_s;

  assign wr_fire_s = in_valid & ~wfull_q;
  assign in_ready  = ~wfull_q;
  assign st3_wen   = wr_fire_s;
  assign st3_waddr = wcnt_q;
  assign st3_wdata = in_data;
  assign st3_sel   = sel_q;
  assign out_data  = st3_rdata;

  // Write counter, frame-full flag and bank select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= WCNT_ZERO;
      wfull_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wfull_q <= wfull_d;
      sel_q   <= sel_d;
    end
  end

  // A write and a swap never coincide: writes need wfull low, a swap needs it high.
  always_comb begin
    wcnt_d  = wcnt_q;
    wfull_d = wfull_q;
    sel_d   = sel_q;
    if (wr_fire_s) begin
      wcnt_d = wcnt_q + WCNT_ONE;
      if (wcnt_q == WCNT_MAX) begin
        wfull_d = 1'b1;
      end else begin
        wfull_d = wfull_q;
      end
    end else begin
      wcnt_d = wcnt_q;
    end
    if (swap_ack_s) begin
      sel_d   = ~sel_q;
      wfull_d = 1'b0;
    end else begin
      sel_d   = sel_q;
    end
  end

  st3_rd_seq #(
    .OUT_ADDR_WIDTH (OUT_ADDR_WIDTH),
    .CHANNEL_NUM    (CHANNEL_NUM),
    .LATENCY        (LATENCY)
  ) u_rd (
    .clk       (clk),
    .rst_n     (rst_n),
    .swap_req  (wfull_q),
    .out_ready (out_ready),
    .swap_ack  (swap_ack_s),
    .idle      (rd_idle_s),
    .out_valid (out_valid),
    .out_last  (out_last),
    .raddr     (st3_raddr)
  );

  st3_param_chk #(
    .IN_DATA_WIDTH  (IN_DATA_WIDTH),
    .IN_ADDR_WIDTH  (IN_ADDR_WIDTH),
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
    .OUT_ADDR_WIDTH (OUT_ADDR_WIDTH),
    .CHANNEL_NUM    (CHANNEL_NUM),
    .LATENCY        (LATENCY)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .st3_sel   (sel_q),
    .rd_idle   (rd_idle_s),
    .st3_wen   (st3_wen),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_st3_pp_ctrl.sv
// Directed and randomized bench for st3_pp_ctrl with a behavioural pp_st3 buffer model.
module tb_st3_pp_ctrl;

  localparam int IDW   = 64;
  localparam int IAW   = 7;
  localparam int ODW   = 8192;
  localparam int OAW   = 2;
  localparam int CH    = 4;
  localparam int LAT   = 3;
  localparam int WORDS = 128;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [CH-1:0][IDW-1:0]  in_data;
  logic                    st3_sel;
  logic                    st3_wen;
  logic [IAW-1:0]          st3_waddr;
  logic [CH-1:0][IDW-1:0]  st3_wdata;
  logic [OAW-1:0]          st3_raddr;
  logic [ODW-1:0]          st3_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [ODW-1:0]          out_data;
  logic                    out_last;

  int checks = 0;
  int errors = 0;

  st3_pp_ctrl #(
    .IN_DATA_WIDTH (IDW), .IN_ADDR_WIDTH (IAW), .OUT_DATA_WIDTH (ODW),
    .OUT_ADDR_WIDTH (OAW), .CHANNEL_NUM (CH), .LATENCY (LAT)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .st3_sel (st3_sel), .st3_wen (st3_wen), .st3_waddr (st3_waddr),
    .st3_wdata (st3_wdata), .st3_raddr (st3_raddr), .st3_rdata (st3_rdata),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ping-pong buffer: sel=0 writes bank0 and reads bank1, LAT-cycle read.
  logic [ODW-1:0] mem [2][CH];
  logic [ODW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (st3_wen) begin
      for (int c = 0; c < CH; c++) mem[st3_sel ? 1 : 0][c][int'(st3_waddr)*IDW +: IDW] <= st3_wdata[c];
    end
    rd_pipe[0] <= mem[st3_sel ? 0 : 1][st3_raddr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign st3_rdata = rd_pipe[LAT-1];

  // Record accepted rows and sel movements while the read side is busy.
  logic [ODW-1:0] rows_q[$];
  bit             last_q[$];
  int             sel_viol = 0;
  bit             prev_busy = 1'b0;
  logic           prev_sel = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rows_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (rst_n && prev_busy && (st3_sel !== prev_sel)) sel_viol++;
    prev_busy = rst_n && !u_dut.rd_idle_s;
    prev_sel  = st3_sel;
  end

  function automatic logic [IDW-1:0] word(input int tag, input int c, input int w);
    logic [IDW-1:0] r;
    r = {32'(tag), 16'(c), 16'(w)};
    return r;
  endfunction

  function automatic logic [ODW-1:0] exp_row(input int tag, input int c);
    logic [ODW-1:0] r;
    for (int w = 0; w < WORDS; w++) r[w*IDW +: IDW] = word(tag, c, w);
    return r;
  endfunction

  function automatic int row_diff(input logic [ODW-1:0] a, input logic [ODW-1:0] b);
    for (int w = 0; w < WORDS; w++) if (a[w*IDW +: IDW] !== b[w*IDW +: IDW]) return w;
    return -1;
  endfunction

  task automatic send_words(input int tag, input int first, input int n, output bit ok);
    int  w = first;
    int  guard = 0;
    bit  acc;
    ok = 1'b1;
    while (w < first + n) begin
      in_valid = 1'b1;
      for (int c = 0; c < CH; c++) in_data[c] = word(tag, c, w);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) w++;
      guard++;
      if (guard > 2000) begin ok = 1'b0; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_rows(input int n, input int budget, output bit ok);
    int cyc = 0;
    while (rows_q.size() < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (rows_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (st3_sel !== 1'b0)   begin errors++; $display("FAIL reset_sel got %b exp 0", st3_sel); end
    checks++; if (st3_raddr !== 2'd0) begin errors++; $display("FAIL reset_raddr got %0d exp 0", st3_raddr); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    checks++; if (st3_wen !== 1'b0)   begin errors++; $display("FAIL reset_wen got %b exp 0", st3_wen); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rows_q.delete(); last_q.delete();
  endtask

  task automatic test_single_frame();
    int row;
    bit exp_v;
    for (int w = 0; w < WORDS; w++) begin
      in_valid = 1'b1;
      for (int c = 0; c < CH; c++) in_data[c] = word(1, c, w);
      @(negedge clk);
      checks++;
      if (st3_wen !== 1'b1 || st3_waddr !== IAW'(w) || st3_sel !== 1'b0 || st3_wdata[2] !== word(1, 2, w)) begin
        errors++;
        $display("FAIL frame_write w=%0d got wen=%b waddr=%0d sel=%b exp wen=1 waddr=%0d sel=0", w, st3_wen, st3_waddr, st3_sel, w);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || st3_sel !== 1'b0) begin
      errors++; $display("FAIL pre_swap got in_ready=%b sel=%b exp 0 0", in_ready, st3_sel);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < CH*(LAT+1); k++) begin
      @(negedge clk);
      exp_v = ((k % (LAT+1)) == LAT);
      row   = k / (LAT+1);
      if (k == 0) begin
        checks++;
        if (st3_sel !== 1'b1 || in_ready !== 1'b1) begin
          errors++; $display("FAIL swap got sel=%b in_ready=%b exp 1 1", st3_sel, in_ready);
        end
      end
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL lat_pattern k=%0d got %b exp %b", k, out_valid, exp_v);
      end
      checks++;
      if (out_last !== (exp_v && row == CH-1)) begin
        errors++; $display("FAIL out_last k=%0d got %b exp %b", k, out_last, exp_v && row == CH-1);
      end
      if (exp_v) begin
        checks++;
        if (st3_raddr !== OAW'(row) || out_data !== exp_row(1, row)) begin
          errors++; $display("FAIL frame_row%0d got raddr=%0d word0=%h exp raddr=%0d word0=%h",
                             row, st3_raddr, out_data[IDW-1:0], row, word(1, row, 0));
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || rows_q.size() != CH) begin
      errors++; $display("FAIL frame_end got valid=%b rows=%0d exp 0 %0d", out_valid, rows_q.size(), CH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    int d;
    out_ready = 1'b0;
    rows_q.delete(); last_q.delete();
    send_words(2, 0, WORDS, ok1);
    send_words(3, 0, WORDS, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_write_timeout got %b%b exp 11", ok1, ok2); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || st3_raddr !== 2'd0 || st3_sel !== 1'b0) begin
        errors++; $display("FAIL b2b_hold i=%0d got ready=%b valid=%b raddr=%0d sel=%b exp 0 1 0 0",
                           i, in_ready, out_valid, st3_raddr, st3_sel);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_rows(2*CH, 400, ok3);
    out_ready = 1'b0;
    checks++; if (!ok3 || rows_q.size() != 2*CH) begin errors++; $display("FAIL b2b_rows got %0d exp %0d", rows_q.size(), 2*CH); end
    for (int i = 0; i < 2*CH && i < rows_q.size(); i++) begin
      d = row_diff(rows_q[i], exp_row((i < CH) ? 2 : 3, i % CH));
      checks++;
      if (d >= 0 || last_q[i] != ((i % CH) == CH-1)) begin
        errors++; $display("FAIL b2b_row%0d word %0d last=%b got %h exp %h", i, d, last_q[i],
                           rows_q[i][IDW-1:0], word((i < CH) ? 2 : 3, i % CH, 0));
      end
    end
    @(negedge clk);
    checks++; if (st3_sel !== 1'b1) begin errors++; $display("FAIL b2b_sel got %b exp 1", st3_sel); end
    @(posedge clk); #1;
  endtask

  task automatic test_last_row_overlap();
    bit ok1, ok2, ok3, found;
    int d;
    out_ready = 1'b0;
    rows_q.delete(); last_q.delete();
    send_words(4, 0, WORDS, ok1);
    send_words(5, 0, WORDS-1, ok2);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && st3_raddr === 2'd3) begin found = 1'b1; break; end
    end
    checks++; if (!(found && ok1 && ok2)) begin errors++; $display("FAIL ovl_setup got %b%b%b exp 111", found, ok1, ok2); end
    in_valid = 1'b1;
    for (int c = 0; c < CH; c++) in_data[c] = word(5, c, WORDS-1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovl_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || st3_sel !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ovl_edge got valid=%b sel=%b ready=%b exp 0 0 0", out_valid, st3_sel, in_ready);
    end
    @(negedge clk);
    checks++;
    if (st3_sel !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ovl_swap got sel=%b ready=%b exp 1 1", st3_sel, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_rows(2*CH, 200, ok3);
    out_ready = 1'b0;
    checks++; if (!ok3 || rows_q.size() != 2*CH) begin errors++; $display("FAIL ovl_rows got %0d exp %0d", rows_q.size(), 2*CH); end
    for (int i = 0; i < 2*CH && i < rows_q.size(); i++) begin
      d = row_diff(rows_q[i], exp_row((i < CH) ? 4 : 5, i % CH));
      checks++;
      if (d >= 0 || last_q[i] != ((i % CH) == CH-1)) begin
        errors++; $display("FAIL ovl_row%0d word %0d last=%b got %h exp %h", i, d, last_q[i],
                           rows_q[i][IDW-1:0], word((i < CH) ? 4 : 5, i % CH, 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, ok3, found;
    int d;
    out_ready = 1'b0;
    send_words(6, 0, WORDS, ok1);
    send_words(7, 0, 50, ok2);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && st3_raddr === 2'd2) begin found = 1'b1; break; end
    end
    checks++; if (!(found && ok1 && ok2)) begin errors++; $display("FAIL rst_setup got %b%b%b exp 111", found, ok1, ok2); end
    #2;
    rst_n = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (st3_sel !== 1'b0 || st3_raddr !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || st3_wen !== 1'b0) begin
      errors++; $display("FAIL rst_async got sel=%b raddr=%0d ready=%b valid=%b last=%b wen=%b exp 0 0 1 0 0 0",
                         st3_sel, st3_raddr, in_ready, out_valid, out_last, st3_wen);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rows_q.delete(); last_q.delete();
    in_valid = 1'b1;
    for (int c = 0; c < CH; c++) in_data[c] = word(8, c, 0);
    @(negedge clk);
    checks++;
    if (st3_wen !== 1'b1 || st3_waddr !== 7'd0 || st3_sel !== 1'b0) begin
      errors++; $display("FAIL rst_first_write got wen=%b waddr=%0d sel=%b exp 1 0 0", st3_wen, st3_waddr, st3_sel);
    end
    @(posedge clk); #1;
    send_words(8, 1, WORDS-1, ok1);
    out_ready = 1'b1;
    wait_rows(CH, 200, ok3);
    repeat (3*(LAT+1)) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    checks++; if (!(ok1 && ok3) || rows_q.size() != CH) begin errors++; $display("FAIL rst_rows got %0d exp %0d", rows_q.size(), CH); end
    for (int i = 0; i < CH && i < rows_q.size(); i++) begin
      d = row_diff(rows_q[i], exp_row(8, i));
      checks++;
      if (d >= 0) begin
        errors++; $display("FAIL rst_row%0d word %0d got %h exp %h", i, d, rows_q[i][IDW-1:0], word(8, i, 0));
      end
    end
  endtask

  task automatic test_random();
    int d;
    int wguard = 0;
    int rguard = 0;
    rows_q.delete(); last_q.delete();
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          int  w = 0;
          bit  acc;
          while (w < WORDS && wguard < 40000) begin
            in_valid = 1'($urandom_range(0, 1));
            for (int c = 0; c < CH; c++) in_data[c] = word(10 + f, c, w);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) w++;
            wguard++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        while (rows_q.size() < 20*CH && rguard < 40000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          rguard++;
        end
        out_ready = 1'b0;
      end
    join
    checks++; if (rows_q.size() != 20*CH) begin errors++; $display("FAIL rand_rows got %0d exp %0d", rows_q.size(), 20*CH); end
    for (int i = 0; i < 20*CH && i < rows_q.size(); i++) begin
      d = row_diff(rows_q[i], exp_row(10 + i / CH, i % CH));
      checks++;
      if (d >= 0 || last_q[i] != ((i % CH) == CH-1)) begin
        errors++; $display("FAIL rand_row%0d word %0d last=%b got %h exp %h", i, d, last_q[i],
                           rows_q[i][IDW-1:0], word(10 + i / CH, i % CH, 0));
      end
    end
    checks++; if (sel_viol != 0) begin errors++; $display("FAIL sel_stable got %0d changes exp 0", sel_viol); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_last_row_overlap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
